zrb_uart_receiver: RTL and testbench

Single-clock 8N1 UART receiver: the receive-side counterpart of the team's UART transmitter. Samples the serial line at 8× the baud rate using a one-cycle sample strobe from the baud generator, recovers LSB-first data bytes, and presents each byte with a one-cycle valid pulse. It sits between the pad-side `rx` pin and the receive FIFO's write port.

---
 rtl/zrb_uart_pkg.sv | 24 ++
 rtl/zrb_sync2.sv | 32 +++
 rtl/zrb_uart_receiver.sv | 159 +++++++++++++++
 tb/tb_zrb_uart_receiver.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/zrb_uart_pkg.sv
// Shared UART receive definitions: FSM states, oversampling constants, majority helper.
// Pure declarations; no logic or timing of its own.
package zrb_uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_BREAK = 3'd4
  } state_e;

  localparam int         OVERSAMPLE = 8;
  localparam int         CNT_W      = 3;
  localparam logic [2:0] SMP_A      = 3'd3;
  localparam logic [2:0] SMP_B      = 3'd4;
  localparam logic [2:0] SMP_C      = 3'd5;
  localparam logic [2:0] CNT_LAST   = 3'd7;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/zrb_sync2.sv
// Two-flop synchronizer for one asynchronous input, parameterised reset value.
// Latency 2 clk; no flow control.
module zrb_sync2 #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/zrb_uart_receiver.sv
// 8N1 UART receiver, 8x oversampled; valid/frame_error pulse 1 clk after the stop-bit decision tick.
// No backpressure: consumer must take data_out on valid. ZRB_UART_RX_MAJORITY_EN selects 2-of-3 bit voting.
module zrb_uart_receiver
  import zrb_uart_pkg::*;
#(
  parameter int DATA_BITS = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 sample_tick,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 valid,
  output logic                 frame_error,
  output logic                 busy
);

  localparam int             IDX_W    = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

  logic rx_s;

  zrb_sync2 #(.RESET_VAL(1'b1)) u_rx_sync (
    .clk   (clk),
    .reset (reset),
    .d     (rx),
    .q     (rx_s)
  );

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] data_out_q, data_out_d;
  logic                 valid_q, valid_d;
  logic                 frame_error_q, frame_error_d;
  logic                 bit_val;
  logic                 decide;

  assign decide = sample_tick && (cnt_q == SMP_C);

`ifdef ZRB_UART_RX_MAJORITY_EN
  logic smp_a_q, smp_a_d;
  logic smp_b_q, smp_b_d;

  always_comb begin
    smp_a_d = smp_a_q;
    smp_b_d = smp_b_q;
    if (sample_tick && cnt_q == SMP_A) smp_a_d = rx_s;
    if (sample_tick && cnt_q == SMP_B) smp_b_d = rx_s;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      smp_a_q <= 1'b1;
      smp_b_q <= 1'b1;
    end else begin
      smp_a_q <= smp_a_d;
      smp_b_q <= smp_b_d;
    end
  end

  // Third vote is the live sample at the decision tick.
  assign bit_val = maj3(smp_a_q, smp_b_q, rx_s);
`else
  assign bit_val = rx_s;
`endif

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    idx_d         = idx_q;
    shift_d       = shift_q;
    data_out_d    = data_out_q;
    valid_d       = 1'b0;
    frame_error_d = 1'b0;

    if (sample_tick) begin
      cnt_d = cnt_q + 3'd1;
      case (state_q)
        ST_IDLE: begin
          cnt_d = '0;
          // The detect tick itself is bit-tick 0, so the next tick is 1.
          if (!rx_s) begin
            state_d = ST_START;
            cnt_d   = 3'd1;
          end
        end
        ST_START: begin
          if (decide && bit_val) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end else if (cnt_q == CNT_LAST) begin
            state_d = ST_DATA;
            idx_d   = '0;
          end
        end
        ST_DATA: begin
          if (decide) begin
            shift_d                = shift_q >> 1;
            shift_d[DATA_BITS-1]   = bit_val;
          end
          if (cnt_q == CNT_LAST) begin
            if (idx_q == IDX_LAST) state_d = ST_STOP;
            else                   idx_d   = idx_q + IDX_W'(1);
          end
        end
        ST_STOP: begin
          if (decide) begin
            cnt_d = '0;
            if (bit_val) begin
              // Leave half a bit early so the next start edge is caught promptly.
              state_d    = ST_IDLE;
              data_out_d = shift_q;
              valid_d    = 1'b1;
            end else begin
              state_d       = ST_BREAK;
              frame_error_d = 1'b1;
            end
          end
        end
        ST_BREAK: begin
          cnt_d = '0;
          if (rx_s) state_d = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      idx_q         <= '0;
      shift_q       <= '0;
      data_out_q    <= '0;
      valid_q       <= 1'b0;
      frame_error_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      idx_q         <= idx_d;
      shift_q       <= shift_d;
      data_out_q    <= data_out_d;
      valid_q       <= valid_d;
      frame_error_q <= frame_error_d;
    end
  end

  assign data_out    = data_out_q;
  assign valid       = valid_q;
  assign frame_error = frame_error_q;
  assign busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_zrb_uart_receiver.sv
// Bench for zrb_uart_receiver: directed vector table, hand-written reset abort, randomized frames
// checked against a frame-level model (good stop -> byte delivered, bad stop -> one frame error).
module tb_zrb_uart_receiver;

  logic       clk;
  logic       reset;
  logic       sample_tick;
  logic       rx;
  logic [7:0] data_out;
  logic       valid;
  logic       frame_error;
  logic       busy;

  int tests = 0;
  int fails = 0;
  int n_valid = 0;
  int n_fe = 0;

`ifdef ZRB_UART_RX_MAJORITY_EN
  localparam int GLITCH_CNT = 4;
`else
  localparam int GLITCH_CNT = 3;
`endif

  zrb_uart_receiver #(.DATA_BITS(8)) dut (
    .clk         (clk),
    .reset       (reset),
    .sample_tick (sample_tick),
    .rx          (rx),
    .data_out    (data_out),
    .valid       (valid),
    .frame_error (frame_error),
    .busy        (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // One-clk tick every 4 clk.
  initial begin
    sample_tick = 1'b0;
    forever begin
      repeat (3) @(posedge clk);
      #1 sample_tick = 1'b1;
      @(posedge clk);
      #1 sample_tick = 1'b0;
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d", tests);
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  // Pulse counting plus pulse-shape and hold checks on every clk.
  initial begin : monitor
    logic       prev_valid;
    logic       prev_fe;
    logic [7:0] prev_data;
    prev_valid = 1'b0;
    prev_fe    = 1'b0;
    prev_data  = 8'h00;
    forever begin
      @(negedge clk);
      if (reset) begin
        if (valid || frame_error)
          check("valid_fe_exclusive", 32'(valid & frame_error), 32'd0);
        if (valid) begin
          n_valid++;
          check("valid_width", 32'(prev_valid), 32'd0);
        end
        if (frame_error) begin
          n_fe++;
          check("fe_width", 32'(prev_fe), 32'd0);
        end
        if (!valid && data_out !== prev_data)
          check("data_hold", 32'(data_out), 32'(prev_data));
      end
      prev_valid = valid;
      prev_fe    = frame_error;
      prev_data  = data_out;
    end
  end

  // Drive rx for one tick period; the DUT sees this level at the next tick.
  task automatic drive_tick(input logic v);
    rx = v;
    do @(posedge clk); while (sample_tick !== 1'b1);
    #1;
  endtask

  // gbit: -1 none, -2 every data bit equal to 1, else bit position (0 = start).
  task automatic send_frame(input logic [7:0] d, input logic stop, input int gbit, input int gcnt);
    logic [9:0] bits;
    logic       v;
    bits = {stop, d, 1'b0};
    for (int b = 0; b < 10; b++) begin
      for (int s = 0; s < 8; s++) begin
        v = bits[b];
        if (b < 9 && s == gcnt && (gbit == b || (gbit == -2 && b >= 1 && v == 1'b1)))
          v = ~v;
        drive_tick(v);
      end
    end
  endtask

  typedef struct {
    logic [7:0] data;
    logic       stop;
    int         gbit;
    int         gcnt;
    int         start_only;
    int         hold;
    int         idle;
    int         exp_valid;
    int         exp_fe;
    logic [7:0] exp_data;
  } vec_t;

  vec_t tbl[9];

  initial begin : main
    int         v0, f0;
    logic [7:0] model_last;
    logic [7:0] d;
    logic       stop;
    int         gbit, gcnt;

    tbl[0] = '{8'h55, 1'b1, -1, 0, 0, 0,      2, 1, 0, 8'h55};
    tbl[1] = '{8'h00, 1'b1, -1, 0, 0, 0,      0, 1, 0, 8'h00};
    tbl[2] = '{8'hFF, 1'b1, -1, 0, 0, 0,      2, 1, 0, 8'hFF};
    tbl[3] = '{8'h00, 1'b1, -1, 0, 2, 0,     10, 0, 0, 8'hFF};
    tbl[4] = '{8'hA5, 1'b0, -1, 0, 0, 30*8,   3, 0, 1, 8'hFF};
    tbl[5] = '{8'h3C, 1'b1, -1, 0, 0, 0,      2, 1, 0, 8'h3C};
    tbl[6] = '{8'hC3, 1'b1, -2, GLITCH_CNT, 0, 0, 2, 1, 0, 8'hC3};
    tbl[7] = '{8'h01, 1'b1, -1, 0, 0, 0,      1, 1, 0, 8'h01};
    tbl[8] = '{8'h80, 1'b1, -1, 0, 0, 0,      1, 1, 0, 8'h80};

    reset = 1'b0;
    rx    = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_data_out", 32'(data_out), 32'd0);
    check("reset_valid", 32'(valid), 32'd0);
    check("reset_frame_error", 32'(frame_error), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    reset = 1'b1;
    for (int i = 0; i < 4; i++) drive_tick(1'b1);

    for (int i = 0; i < 9; i++) begin
      v0 = n_valid;
      f0 = n_fe;
      if (tbl[i].start_only > 0) begin
        for (int t = 0; t < tbl[i].start_only; t++) drive_tick(1'b0);
      end else begin
        send_frame(tbl[i].data, tbl[i].stop, tbl[i].gbit, tbl[i].gcnt);
      end
      for (int t = 0; t < tbl[i].hold; t++) drive_tick(1'b0);
      for (int t = 0; t < tbl[i].idle; t++) drive_tick(1'b1);
      check($sformatf("vec%0d_valid_count", i), 32'(n_valid - v0), 32'(tbl[i].exp_valid));
      check($sformatf("vec%0d_fe_count", i), 32'(n_fe - f0), 32'(tbl[i].exp_fe));
      check($sformatf("vec%0d_data_out", i), 32'(data_out), 32'(tbl[i].exp_data));
      check($sformatf("vec%0d_busy_idle", i), 32'(busy), 32'd0);
    end

    // Reset during bit 4 of 0x81 aborts the frame silently.
    v0 = n_valid;
    f0 = n_fe;
    for (int t = 0; t < 8; t++) drive_tick(1'b0);
    for (int b = 0; b < 4; b++)
      for (int t = 0; t < 8; t++) drive_tick((8'h81 >> b) & 8'h01);
    for (int t = 0; t < 3; t++) drive_tick(1'b0);
    check("midframe_busy", 32'(busy), 32'd1);
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("midreset_data_out", 32'(data_out), 32'd0);
    check("midreset_valid", 32'(valid), 32'd0);
    check("midreset_frame_error", 32'(frame_error), 32'd0);
    check("midreset_busy", 32'(busy), 32'd0);
    rx = 1'b1;
    @(posedge clk);
    #1 reset = 1'b1;
    for (int t = 0; t < 12; t++) drive_tick(1'b1);
    check("abort_no_valid", 32'(n_valid - v0), 32'd0);
    check("abort_no_fe", 32'(n_fe - f0), 32'd0);
    send_frame(8'h7E, 1'b1, -1, 0);
    drive_tick(1'b1);
    check("after_reset_valid", 32'(n_valid - v0), 32'd1);
    check("after_reset_data", 32'(data_out), 32'h7E);

    // Randomized frames against the frame-level model.
    model_last = 8'h7E;
    for (int i = 0; i < 40; i++) begin
      d    = 8'($urandom);
      stop = ($urandom_range(0, 5) != 0);
      gbit = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 8)) : -1;
      case ($urandom_range(0, 4))
        0: gcnt = 1;
        1: gcnt = 2;
        2: gcnt = 3;
        3: gcnt = 4;
        default: gcnt = 6;
      endcase
      for (int t = 0; t < int'($urandom_range(0, 3)); t++) drive_tick(1'b1);
      v0 = n_valid;
      f0 = n_fe;
      send_frame(d, stop, gbit, gcnt);
      if (!stop) begin
        for (int t = 0; t < int'($urandom_range(0, 20)); t++) drive_tick(1'b0);
        for (int t = 0; t < int'($urandom_range(1, 3)); t++) drive_tick(1'b1);
      end
      if (stop) model_last = d;
      check($sformatf("rnd%0d_valid_count", i), 32'(n_valid - v0), stop ? 32'd1 : 32'd0);
      check($sformatf("rnd%0d_fe_count", i), 32'(n_fe - f0), stop ? 32'd0 : 32'd1);
      check($sformatf("rnd%0d_data_out", i), 32'(data_out), 32'(model_last));
    end

    for (int t = 0; t < 4; t++) drive_tick(1'b1);
    check("final_busy", 32'(busy), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
